// File: rtl/adder_pkg.sv
// Shared definitions for the multi-word add/subtract sequencer.
package adder_pkg;

  // Width of the shared adder; every operand is processed in slices of this size.
  localparam int WORD_W = 16;

  // Sequencer phases: waiting for work, stepping words, holding the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/multiword_add_sequencer_rca.sv
// Single-word ripple-carry adder: sum = a + b + cin, with carry out.
module ripple_carry_adder
  import adder_pkg::*;
(
  input  logic [WORD_W-1:0] a_i,
  input  logic [WORD_W-1:0] b_i,
  input  logic              cin_i,
  output logic [WORD_W-1:0] sum_o,
  output logic              cout_o
);

  logic [WORD_W-1:0] prop;
  logic [WORD_W-1:0] gen;

  // Per-bit propagate and generate terms.
  generate
    for (genvar gi = 0; gi < WORD_W; gi++) begin : g_pg
      assign prop[gi] = a_i[gi] ^ b_i[gi];
      assign gen[gi]  = a_i[gi] & b_i[gi];
    end
  endgenerate

  // Ripple the carry from bit 0 upward through every bit position.
  always_comb begin
    logic c;
    c     = cin_i;
    sum_o = '0;
    for (int i = 0; i < WORD_W; i++) begin
      sum_o[i] = prop[i] ^ c;
      c        = gen[i] | (prop[i] & c);
    end
    cout_o = c;
  end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Multi-precision add/subtract that steps one shared 16-bit adder over
// WORDS cycles, least-significant word first, with a registered carry.
module multiword_add_sequencer
  import adder_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORDS*WORD_W-1:0]   a,
  input  logic [WORDS*WORD_W-1:0]   b,
  input  logic                      sub,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WORDS*WORD_W-1:0]   sum,
  output logic                      cout,
  output logic                      ovf,
  output logic                      busy
);

  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               idx_q;
  logic [WORDS-1:0][WORD_W-1:0]   a_q, b_q, sum_q;
  logic                           sub_q;
  logic                           carry_q;
  logic                           cout_q;
  logic                           ovf_q;

  logic [WORD_W-1:0]              a_word, b_eff, add_sum;
  logic                           add_cin, add_cout;
  logic                           last_word;

  // Select the current word pair; subtraction is A + ~B + 1 with the +1 as carry-in.
  always_comb begin
    a_word    = a_q[idx_q];
    b_eff     = sub_q ? ~b_q[idx_q] : b_q[idx_q];
    add_cin   = (idx_q == '0) ? sub_q : carry_q;
    last_word = (idx_q == IDX_W'(WORDS - 1));
  end

  ripple_carry_adder u_adder (
    .a_i    (a_word),
    .b_i    (b_eff),
    .cin_i  (add_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: accept only from IDLE, so IDLE is visited between operations.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last_word) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, per-word accumulation and final flag registration.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
            b_q   <= b;
            sub_q <= sub;
            idx_q <= '0;
          end
        end
        RUN: begin
          sum_q[idx_q] <= add_sum;
          carry_q      <= add_cout;
          if (last_word) begin
            cout_q <= add_cout;
            // Signed overflow: like-signed inputs producing an opposite-signed result.
            ovf_q  <= (a_word[WORD_W-1] == b_eff[WORD_W-1]) &&
                      (add_sum[WORD_W-1] != a_word[WORD_W-1]);
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake and result outputs decoded from the registered state.
  always_comb begin
    in_ready  = (state_q == IDLE) && !rst;
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    sum       = sum_q;
    cout      = cout_q;
    ovf       = ovf_q;
  end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Self-checking bench for multiword_add_sequencer with WORDS=4 (64-bit operands).
module tb_multiword_add_sequencer;

  localparam int WORDS = 4;
  localparam int W     = WORDS * 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int total = 0;
  int bad   = 0;

  multiword_add_sequencer #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic on the whole operands.
  function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s,
                                output logic [W-1:0] so, output logic co, output logic vo);
    logic [W:0]        u;
    logic signed [W:0] r;
    if (s) begin
      u  = {1'b0, av} - {1'b0, bv};
      co = (av >= bv);
      r  = $signed({av[W-1], av}) - $signed({bv[W-1], bv});
    end else begin
      u  = {1'b0, av} + {1'b0, bv};
      co = u[W];
      r  = $signed({av[W-1], av}) + $signed({bv[W-1], bv});
    end
    so = u[W-1:0];
    vo = (r[W] != r[W-1]);
  endfunction

  function automatic logic [W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // Pick words from corner values most of the time to stress carry chains.
  function automatic logic [W-1:0] rnd_corner();
    logic [W-1:0] v;
    for (int k = 0; k < WORDS; k++) begin
      case ($urandom_range(0, 5))
        0: v[k*16 +: 16] = 16'h0000;
        1: v[k*16 +: 16] = 16'hFFFF;
        2: v[k*16 +: 16] = 16'h8000;
        3: v[k*16 +: 16] = 16'h7FFF;
        default: v[k*16 +: 16] = 16'($urandom());
      endcase
    end
    return v;
  endfunction

  // One full transaction: accept, latency, result, optional backpressure, release.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic s, input int hold);
    logic [W-1:0] es;
    logic         ec, ev;
    model(av, bv, s, es, ec, ev);
    @(negedge clk);
    a = av; b = bv; sub = s; in_valid = 1'b1; out_ready = 1'b0;
    chk({tag, ":in_ready_idle"}, W'(in_ready), W'(1));
    @(posedge clk); #1;
    in_valid = 1'b0; a = rnd64(); b = rnd64(); sub = ~s;
    chk({tag, ":busy_run"}, W'(busy), W'(1));
    chk({tag, ":in_ready_run"}, W'(in_ready), W'(0));
    for (int k = 1; k < WORDS; k++) begin
      @(posedge clk); #1;
    end
    chk({tag, ":early_valid"}, W'(out_valid), W'(0));
    @(posedge clk); #1;
    chk({tag, ":latency"}, W'(out_valid), W'(1));
    chk({tag, ":sum"}, sum, es);
    chk({tag, ":cout"}, W'(cout), W'(ec));
    chk({tag, ":ovf"}, W'(ovf), W'(ev));
    $display("op %s a=%h b=%h sub=%0d sum=%h cout=%0d ovf=%0d exp=%h/%0d/%0d",
             tag, av, bv, s, sum, cout, ovf, es, ec, ev);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1; a = rnd64(); b = rnd64(); sub = $urandom_range(0, 1);
      @(posedge clk); #1;
      chk({tag, ":hold_valid"}, W'(out_valid), W'(1));
      chk({tag, ":hold_sum"}, sum, es);
      chk({tag, ":hold_flags"}, W'({cout, ovf}), W'({ec, ev}));
      chk({tag, ":hold_in_ready"}, W'(in_ready), W'(0));
    end
    // Release with a request pending: DONE must not accept it.
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    chk({tag, ":release_valid"}, W'(out_valid), W'(0));
    chk({tag, ":no_accept_done"}, W'(busy), W'(0));
    chk({tag, ":in_ready_after"}, W'(in_ready), W'(1));
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset:out_valid", W'(out_valid), W'(0));
    chk("reset:sum", sum, W'(0));
    chk("reset:flags", W'({cout, ovf}), W'(0));
    chk("reset:busy", W'(busy), W'(0));
    chk("reset:in_ready_in_rst", W'(in_ready), W'(0));
    rst = 1'b0;
    #1;
    chk("reset:in_ready", W'(in_ready), W'(1));

    run_op("carry16", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 0);
    run_op("fullchain", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0);
    run_op("sub_ovf", 64'h8000_0000_0000_0000, 64'h1, 1'b1, 0);
    run_op("sub_borrow", 64'h5, 64'h7, 1'b1, 0);
    run_op("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 0);
    run_op("backpress", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 5);
    run_op("after_bp", 64'h0000_0001_0000_0000, 64'h0000_0000_0000_0001, 1'b1, 0);

    // Reset in the middle of RUN, when the word index has reached 2.
    @(negedge clk);
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst:busy_before", W'(busy), W'(1));
    rst = 1'b1;
    #1;
    chk("midrst:in_ready_in_rst", W'(in_ready), W'(0));
    @(posedge clk); #1;
    chk("midrst:out_valid", W'(out_valid), W'(0));
    chk("midrst:sum", sum, W'(0));
    chk("midrst:busy", W'(busy), W'(0));
    rst = 1'b0;
    #1;
    chk("midrst:in_ready", W'(in_ready), W'(1));
    $display("op midrst aborted");
    run_op("post_rst", 64'h1234, 64'h1, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] av, bv;
      av = ($urandom_range(0, 1) == 1) ? rnd_corner() : rnd64();
      bv = ($urandom_range(0, 1) == 1) ? rnd_corner() : rnd64();
      run_op($sformatf("rnd%0d", i), av, bv, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multiword_add_sequencer.md
Name: multiword_add_sequencer

Overview:
Sequences one shared 16-bit ripple-carry adder over WORDS cycles to perform multi-precision add/subtract on WORDS*16-bit operands.
- One word per cycle, LSW first; the carry is registered between words.
- Valid/ready on the input and the output, so it drops into the DSP datapath wherever wide accumulator or offset arithmetic is needed without instantiating a wide adder.

Parameters:
WORDS, 4, number of 16-bit words per operand (>=1); default gives 64-bit arithmetic
WORD_W, 16, word width; fixed by the adder, taken from package, not overridable

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operation request
in_ready  output  1  block can accept an operation
a  input  WORDS*16  operand A, word k = a[16k+15:16k]
b  input  WORDS*16  operand B
sub  input  1  0: A+B, 1: A-B
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
sum  output  WORDS*16  result
cout  output  1  final carry out; for sub, 1 = no borrow (A>=B unsigned)
ovf  output  1  two's-complement signed overflow of the full-width result
busy  output  1  high in RUN or DONE

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset (any state, including mid-RUN):
  - state<=IDLE, word index<=0, carry_q<=0.
  - sum/cout/ovf<=0, out_valid<=0.
  - In-flight operation discarded. No output is produced for it.
- in_ready is combinational: 1 only in IDLE and rst=0.
- States:
  - IDLE: on in_valid&in_ready, latch a, b, sub; idx<=0; go RUN.
  - RUN: each cycle drive the adder with:
    - a word: a_q[idx]
    - b word: sub ? ~b_q[idx] : b_q[idx]
    - carry in: (idx==0) ? sub : carry_q
  - Write adder sum into sum word idx; carry_q<=adder cout; idx<=idx+1.
  - When idx==WORDS-1, also:
    - register cout (the adder's final carry out);
    - register ovf = (a_msb == b_eff_msb) & (sum_msb != a_msb);
    - go DONE.
  - DONE: out_valid=1. On out_ready, go IDLE.
- Latency: acceptance at edge E0 -> out_valid high after edge E0+WORDS. Minimum op-to-op period is WORDS+2 cycles with out_ready tied high.
- Output hold:
  - While out_valid & !out_ready, sum/cout/ovf are stable.
  - While busy, in_ready=0.
  - Input changes after acceptance have no effect.
- No accept in DONE, even when out_ready=1 that cycle; IDLE is always visited.
- Partial sum words may be visible during RUN. Consumers sample only when out_valid=1.
- WORDS=1: a single RUN cycle; carry-in = sub.
- idx width: $clog2(WORDS) with minimum 1; no wrap beyond WORDS-1.

Decomposition:
- adder_pkg: WORD_W=16 and state typedef {IDLE, RUN, DONE}.
- One sub-module: one ripple_carry_adder instance, the existing 16-bit adder, unchanged.
- Word muxing, b inversion, carry register and FSM live in this block.

Test Plan (WORDS=4):
1. Add 0x0000_0000_0000_FFFF + 0x1 -> sum 0x0000_0000_0001_0000, cout 0, ovf 0; out_valid rises exactly 4 edges after the accept edge.
2. Add 0xFFFF_FFFF_FFFF_FFFF + 0x1 -> sum 0, cout 1, ovf 0 (full-chain carry).
3. Sub 0x8000_0000_0000_0000 - 0x1 -> 0x7FFF_FFFF_FFFF_FFFF, cout 1, ovf 1; sub 0x5 - 0x7 -> 0xFFFF_FFFF_FFFF_FFFE, cout 0, ovf 0.
4. Add 0x7FFF_FFFF_FFFF_FFFF + 0x1 -> 0x8000_0000_0000_0000, ovf 1, cout 0.
5. Backpressure: out_ready held 0 for 5 cycles -> outputs stable, in_ready 0, inputs toggled with no effect. Then out_ready=1 -> IDLE, in_ready 1 next cycle, next op accepted and correct.
6. Reset asserted in RUN at idx=2 -> after that edge: out_valid 0, sum 0, in_ready 1 once rst drops. A following add 0x1234 + 0x1 gives 0x1235, with no stale carry.
